nic_tx_inject: RTL and testbench

//  NIC transmit side: accepts one DATA_WIDTH flit from the PE over a valid/ready handshake.

---
 rtl/nic_tx_inject.sv | 115 +++++++++++
 tb/tb_nic_tx_inject.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/nic_tx_inject.sv
// NIC transmit injector: stages one PE flit in a holding register and writes it into the
// router's one-entry channel buffer, honouring buffer-full, tx enable and a minimum inter-flit gap.
module nic_tx_inject #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned GAP_WIDTH  = 4,
    parameter int unsigned MIN_GAP    = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pe_valid,
    input  logic [DATA_WIDTH-1:0] pe_data,
    output logic                  pe_ready,
    input  logic                  tx_en,
    input  logic                  net_full,
    output logic                  net_we,
    output logic [DATA_WIDTH-1:0] net_data,
    output logic                  busy,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  tx_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic                  send_ok;
    logic                  load;
    logic                  stall_inc;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; net_we is a same-cycle function of state and inputs
    always_comb begin
        state_nxt = state;
        send_ok   = tx_en & ~net_full & (gap_cnt == '0);
        load      = 1'b0;
        net_we    = 1'b0;
        pe_ready  = 1'b0;
        busy      = 1'b0;
        stall_inc = 1'b0;
        case (state)
            IDLE: begin
                pe_ready = 1'b1;
                if (pe_valid) begin
                    load      = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                busy      = 1'b1;
                stall_inc = tx_en & net_full;
                if (send_ok) begin
                    net_we    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holding register only changes on a PE transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_data <= '0;
        end else if (load) begin
            hold_data <= pe_data;
        end
    end

    assign net_data = hold_data;

    // Gap counter reloads on a send and drains in every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt <= '0;
        end else if (net_we) begin
            gap_cnt <= GAP_WIDTH'(MIN_GAP);
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
        end
    end

    // Statistics: tx_count wraps, stall_count saturates, clear has priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_count    <= '0;
            stall_count <= '0;
        end else if (cnt_clr) begin
            tx_count    <= '0;
            stall_count <= '0;
        end else begin
            if (net_we) begin
                tx_count <= tx_count + CNT_WIDTH'(1);
            end
            if (stall_inc && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_nic_tx_inject.sv
// Directed bench for nic_tx_inject: instance a uses default parameters,
// instance b uses MIN_GAP=3 and 4-bit counters for gap and wrap/saturation cases.
module tb_nic_tx_inject;

    logic        clk;
    logic        reset;

    logic        a_pe_valid, a_pe_ready, a_tx_en, a_net_full, a_net_we, a_busy, a_cnt_clr;
    logic [63:0] a_pe_data, a_net_data;
    logic [15:0] a_tx_count, a_stall_count;

    logic        b_pe_valid, b_pe_ready, b_tx_en, b_net_full, b_net_we, b_busy, b_cnt_clr;
    logic [63:0] b_pe_data, b_net_data;
    logic [3:0]  b_tx_count, b_stall_count;

    int checks = 0;
    int errors = 0;

    nic_tx_inject u_a (
        .clk         (clk),
        .reset       (reset),
        .pe_valid    (a_pe_valid),
        .pe_data     (a_pe_data),
        .pe_ready    (a_pe_ready),
        .tx_en       (a_tx_en),
        .net_full    (a_net_full),
        .net_we      (a_net_we),
        .net_data    (a_net_data),
        .busy        (a_busy),
        .cnt_clr     (a_cnt_clr),
        .tx_count    (a_tx_count),
        .stall_count (a_stall_count)
    );

    nic_tx_inject #(
        .DATA_WIDTH (64),
        .GAP_WIDTH  (4),
        .MIN_GAP    (3),
        .CNT_WIDTH  (4)
    ) u_b (
        .clk         (clk),
        .reset       (reset),
        .pe_valid    (b_pe_valid),
        .pe_data     (b_pe_data),
        .pe_ready    (b_pe_ready),
        .tx_en       (b_tx_en),
        .net_full    (b_net_full),
        .net_we      (b_net_we),
        .net_data    (b_net_data),
        .busy        (b_busy),
        .cnt_clr     (b_cnt_clr),
        .tx_count    (b_tx_count),
        .stall_count (b_stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset      = 1'b0;
        a_pe_valid = 1'b1;  a_pe_data = 64'hDEAD;  a_tx_en = 1'b1;
        a_net_full = 1'b0;  a_cnt_clr = 1'b0;
        b_pe_valid = 1'b0;  b_pe_data = 64'h0;     b_tx_en = 1'b1;
        b_net_full = 1'b0;  b_cnt_clr = 1'b0;

        // Reset: PE offer ignored, outputs at reset values
        @(negedge clk); #1;
        chk("rst_pe_ready", 64'(a_pe_ready), 64'd1);
        chk("rst_busy",     64'(a_busy),     64'd0);
        chk("rst_net_we",   64'(a_net_we),   64'd0);
        chk("rst_net_data", a_net_data,      64'd0);
        chk("rst_tx_count", 64'(a_tx_count), 64'd0);
        chk("rst_stall",    64'(a_stall_count), 64'd0);
        reset      = 1'b1;
        a_pe_valid = 1'b0;

        // 1: single flit, sent one cycle after load
        @(negedge clk);
        a_pe_valid = 1'b1; a_pe_data = 64'hA5;
        @(negedge clk);
        a_pe_valid = 1'b0; #1;
        chk("t1_net_we",   64'(a_net_we),   64'd1);
        chk("t1_net_data", a_net_data,      64'hA5);
        chk("t1_pe_ready", 64'(a_pe_ready), 64'd0);
        chk("t1_busy",     64'(a_busy),     64'd1);
        @(negedge clk); #1;
        chk("t1_we_drop",  64'(a_net_we),   64'd0);
        chk("t1_tx_count", 64'(a_tx_count), 64'd1);
        chk("t1_idle",     64'(a_busy),     64'd0);

        // 2: buffer full for 5 cycles, then one write
        a_pe_valid = 1'b1; a_pe_data = 64'h1; a_net_full = 1'b1;
        @(negedge clk);
        a_pe_valid = 1'b0; #1;
        chk("t2_we_full0", 64'(a_net_we), 64'd0);
        repeat (4) @(negedge clk);
        #1;
        chk("t2_we_full4", 64'(a_net_we), 64'd0);
        chk("t2_stall4",   64'(a_stall_count), 64'd4);
        @(negedge clk);
        a_net_full = 1'b0; #1;
        chk("t2_stall5",   64'(a_stall_count), 64'd5);
        chk("t2_net_we",   64'(a_net_we),   64'd1);
        chk("t2_net_data", a_net_data,      64'h1);
        @(negedge clk); #1;
        chk("t2_we_single", 64'(a_net_we),  64'd0);
        chk("t2_tx_count",  64'(a_tx_count), 64'd2);
        chk("t2_stall_hold", 64'(a_stall_count), 64'd5);

        // 4: tx_en low holds the flit; no stall counting even with buffer full
        a_pe_valid = 1'b1; a_pe_data = 64'h44; a_tx_en = 1'b0; a_net_full = 1'b1;
        @(negedge clk);
        a_pe_valid = 1'b0;
        repeat (10) begin
            #1;
            chk("t4_no_we", 64'(a_net_we), 64'd0);
            @(negedge clk);
        end
        #1;
        chk("t4_stall",    64'(a_stall_count), 64'd5);
        chk("t4_busy",     64'(a_busy),        64'd1);
        chk("t4_net_data", a_net_data,         64'h44);
        a_net_full = 1'b0; a_tx_en = 1'b1; #1;
        chk("t4_net_we",   64'(a_net_we), 64'd1);
        @(negedge clk); #1;
        chk("t4_tx_count", 64'(a_tx_count), 64'd3);

        // 5: async reset while holding a blocked flit
        a_pe_valid = 1'b1; a_pe_data = 64'h55; a_net_full = 1'b1;
        @(negedge clk);
        a_pe_valid = 1'b0; #1;
        chk("t5_busy_pre", 64'(a_busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5_net_we",   64'(a_net_we),      64'd0);
        chk("t5_busy",     64'(a_busy),        64'd0);
        chk("t5_net_data", a_net_data,         64'd0);
        chk("t5_tx_count", 64'(a_tx_count),    64'd0);
        chk("t5_stall",    64'(a_stall_count), 64'd0);
        chk("t5_pe_ready", 64'(a_pe_ready),    64'd1);
        a_pe_valid = 1'b1; a_pe_data = 64'h66;
        @(negedge clk); #1;
        chk("t5_ignored",  64'(a_busy), 64'd0);
        reset = 1'b1; a_pe_valid = 1'b0; a_net_full = 1'b0;
        @(negedge clk); #1;
        chk("t5_no_write", 64'(a_net_we),   64'd0);
        chk("t5_post_tx",  64'(a_tx_count), 64'd0);

        // 3 and 6: continuous offer with MIN_GAP=3 sends every 4 cycles; 17 sends wrap 4-bit count
        b_pe_valid = 1'b1; b_pe_data = 64'hBEEF;
        for (int i = 1; i <= 65; i++) begin
            @(negedge clk); #1;
            chk($sformatf("t3_we_c%0d", i),    64'(b_net_we),   64'((i % 4) == 1));
            chk($sformatf("t3_ready_c%0d", i), 64'(b_pe_ready), 64'((i % 4) == 2));
            if (i == 65) b_pe_valid = 1'b0;
        end
        @(negedge clk); #1;
        chk("t6_tx_wrap", 64'(b_tx_count), 64'd1);
        b_net_full = 1'b1; b_pe_valid = 1'b1; b_pe_data = 64'h77;
        @(negedge clk);
        b_pe_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("t6_stall_sat", 64'(b_stall_count), 64'd15);
        chk("t6_no_we",     64'(b_net_we),      64'd0);
        chk("t6_busy",      64'(b_busy),        64'd1);
        b_net_full = 1'b0; b_cnt_clr = 1'b1; #1;
        chk("t6_send",      64'(b_net_we),  64'd1);
        chk("t6_data",      b_net_data,     64'h77);
        @(negedge clk);
        b_cnt_clr = 1'b0; #1;
        chk("t6_clr_tx",    64'(b_tx_count),    64'd0);
        chk("t6_clr_stall", 64'(b_stall_count), 64'd0);
        chk("t6_idle",      64'(b_busy),        64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
